regfile_wb_queue: RTL and testbench

- Write-back side of the general-purpose register file.
- Accepts retiring results from the pipeline over a valid/ready handshake and buffers them in an in-order FIFO.
- Drives the register file's single write port (wr/rw/d) whenever that port is granted.
- Provides a per-read-port bypass lookup so decode-stage readers see values still pending in the queue.

---
 rtl/regfile_wb_queue_pkg.sv | 22 ++
 rtl/regfile_wb_match.sv | 38 +++
 rtl/regfile_wb_queue.sv | 114 +++++++++++
 tb/tb_regfile_wb_queue.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
// Shared types and helpers for the register-file write-back queue.
// Entry layout, the zero-register constant and a constant log2.
package regfile_wb_queue_pkg;

    localparam int WB_ADDR_W = 5;
    localparam int WB_DATA_W = 32;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/regfile_wb_match.sv
// Youngest-first address match across the queue entries for one
// bypass read port; entries are scanned oldest to youngest from head.
module regfile_wb_match
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int PTR_W      = log2(DEPTH)
) (
    input  logic [DEPTH-1:0]                 valid_i,
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_i,
    input  logic [PTR_W-1:0]                 head_i,
    input  logic [ADDR_WIDTH-1:0]            lk_addr_i,
    output logic                             hit_o,
    output logic [DATA_WIDTH-1:0]            data_o
);

    logic [PTR_W-1:0] idx;

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        idx    = '0;
        if (lk_addr_i != ADDR_WIDTH'(REG_ZERO)) begin
            for (int k = 0; k < DEPTH; k++) begin
                idx = head_i + PTR_W'(k);
                if (valid_i[idx] && (addr_i[idx] == lk_addr_i)) begin
                    hit_o  = 1'b1;
                    data_o = data_i[idx];
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order write-back FIFO in front of the register file write port,
// with per-read-port bypass of values still pending in the queue.
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_W,
    parameter int ADDR_WIDTH = WB_ADDR_W,
    parameter int DEPTH      = 4,
    parameter int RD_DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ADDR_WIDTH-1:0]          in_addr,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           wr_grant,
    output logic                           wr,
    output logic [ADDR_WIDTH-1:0]          rw,
    output logic [DATA_WIDTH-1:0]          d,
    input  logic [ADDR_WIDTH*RD_DEPTH-1:0] lk_addr,
    output logic [RD_DEPTH-1:0]            lk_hit,
    output logic [DATA_WIDTH*RD_DEPTH-1:0] lk_data,
    output logic [log2(DEPTH):0]           count
);

    localparam int PTR_W = log2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;

    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

    logic push;
    logic enq;
    logic pop;

    // Ready comes from registered occupancy only, never from wr_grant.
    assign in_ready = rst & (count_q < CNT_W'(DEPTH));
    assign push     = in_valid & in_ready;
    assign enq      = push & (in_addr != ADDR_WIDTH'(REG_ZERO));

    assign wr  = (count_q != '0) & wr_grant & rst;
    assign pop = wr;
    assign rw  = addr_q[head_q];
    assign d   = data_q[head_q];

    assign count = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        count_d = count_q + CNT_W'(enq) - CNT_W'(pop);
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[tail_q] <= in_addr;
            data_q[tail_q] <= in_data;
        end
    end

    logic [RD_DEPTH-1:0] hit_raw;
    logic [RD_DEPTH-1:0][DATA_WIDTH-1:0] data_raw;

    for (genvar i = 0; i < RD_DEPTH; i++) begin : g_lk
        regfile_wb_match #(
            .DEPTH      (DEPTH),
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .PTR_W      (PTR_W)
        ) u_match (
            .valid_i   (valid_q),
            .addr_i    (addr_q),
            .data_i    (data_q),
            .head_i    (head_q),
            .lk_addr_i (lk_addr[i*ADDR_WIDTH +: ADDR_WIDTH]),
            .hit_o     (hit_raw[i]),
            .data_o    (data_raw[i])
        );

        assign lk_hit[i] = hit_raw[i] & rst;
        assign lk_data[i*DATA_WIDTH +: DATA_WIDTH] =
            rst ? data_raw[i] : '0;
    end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue: expected writes go into a
// scoreboard queue, a negedge monitor checks every wr beat against it.
module tb_regfile_wb_queue;
    import regfile_wb_queue_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wr_grant;
    logic        wr;
    logic [4:0]  rw;
    logic [31:0] d;
    logic [9:0]  lk_addr;
    logic [1:0]  lk_hit;
    logic [63:0] lk_data;
    logic [2:0]  count;

    int n_pass;
    int n_total;

    wb_entry_t exp_q[$];

    regfile_wb_queue dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .wr_grant (wr_grant),
        .wr       (wr),
        .rw       (rw),
        .d        (d),
        .lk_addr  (lk_addr),
        .lk_hit   (lk_hit),
        .lk_data  (lk_data),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [4:0] a, input logic [31:0] v);
        wb_entry_t e;
        e.addr = a;
        e.data = v;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] a, input logic [31:0] v);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = v;
    endtask

    always @(negedge clk) begin
        wb_entry_t e;
        if (wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", wr, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_rw", rw, e.addr);
                chk("wr_d", d, e.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_pass   = 0;
        n_total  = 0;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_addr  = 5'd1;
        in_data  = 32'hAA;
        wr_grant = 1'b1;
        lk_addr  = '0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_wr", wr, 0);
            chk("rst_lk_hit", lk_hit, 0);
        end
        tick();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_count", count, 0);

        drive(5'd5, 32'hDEADBEEF);
        lk_addr = {5'd0, 5'd5};
        #1;
        chk("push_not_visible", lk_hit, 2'b00);
        push_exp(5'd5, 32'hDEADBEEF);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("single_count", count, 1);
        chk("head_hit", lk_hit, 2'b01);
        chk("head_data", lk_data[31:0], 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("single_drained", count, 0);
        chk("single_wr_low", wr, 0);

        wr_grant = 1'b0;
        drive(5'd3, 32'h11); push_exp(5'd3, 32'h11); tick();
        drive(5'd3, 32'h22); push_exp(5'd3, 32'h22); tick();
        drive(5'd7, 32'h33); push_exp(5'd7, 32'h33); tick();
        drive(5'd9, 32'h44); push_exp(5'd9, 32'h44); tick();
        drive(5'd2, 32'h55);
        lk_addr = {5'd8, 5'd3};
        @(negedge clk);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        chk("lk_3_8_hit", lk_hit, 2'b01);
        chk("lk_3_data", lk_data[31:0], 32'h22);
        chk("lk_8_data", lk_data[63:32], 32'h0);
        lk_addr = {5'd9, 5'd7};
        #1;
        chk("lk_7_9_hit", lk_hit, 2'b11);
        chk("lk_7_data", lk_data[31:0], 32'h33);
        chk("lk_9_data", lk_data[63:32], 32'h44);
        lk_addr = '0;
        #1;
        chk("lk_zero_miss", lk_hit, 2'b00);
        tick();

        wr_grant = 1'b1;
        @(negedge clk);
        chk("stall_count", count, 4);
        chk("full_grant_ready", in_ready, 0);
        tick();
        @(negedge clk);
        chk("after_pop_ready", in_ready, 1);
        chk("after_pop_count", count, 3);
        push_exp(5'd2, 32'h55);
        tick();
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("drain_count", count, 0);

        drive(5'd0, 32'hFFFFFFFF);
        #1;
        chk("r0_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        lk_addr  = '0;
        @(negedge clk);
        chk("r0_count", count, 0);
        chk("r0_lk_miss", lk_hit, 2'b00);

        wr_grant = 1'b0;
        drive(5'd1, 32'hA1); tick();
        drive(5'd2, 32'hA2); tick();
        drive(5'd3, 32'hA3); tick();
        in_valid = 1'b0;
        lk_addr  = {5'd2, 5'd1};
        @(negedge clk);
        chk("mid_count", count, 3);
        chk("mid_lk_hit", lk_hit, 2'b11);
        rst = 1'b0;
        #1;
        chk("mid_rst_lk_hit", lk_hit, 2'b00);
        chk("mid_rst_in_ready", in_ready, 0);
        tick();
        rst      = 1'b1;
        wr_grant = 1'b1;
        @(negedge clk);
        chk("mid_post_count", count, 0);
        chk("mid_post_wr", wr, 0);
        chk("mid_post_lk_hit", lk_hit, 2'b00);
        chk("mid_post_ready", in_ready, 1);
        repeat (2) @(negedge clk);
        chk("mid_still_empty", count, 0);

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
